// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and width helpers for the FIFO write-port arbiter.
//   arb_state_e    - arbiter FSM state (StIdle, StGrant)
//   OWNER_W/BCNT_W - owner index and beat counter widths for the default configuration
//   STALL_W        - width of the optional stall counter
//   owner_w()/bcnt_w() - the same widths for any NREQ / BURST_MAX
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } arb_state_e;

  localparam int unsigned DSIZE_DEF     = 8;
  localparam int unsigned NREQ_DEF      = 4;
  localparam int unsigned BURST_MAX_DEF = 4;

  localparam int unsigned OWNER_W = $clog2(NREQ_DEF);
  localparam int unsigned BCNT_W  = $clog2(BURST_MAX_DEF + 1);
  localparam int unsigned STALL_W = 16;

  function automatic int unsigned owner_w(input int unsigned nreq);
    return (nreq <= 2) ? 1 : $clog2(nreq);
  endfunction

  function automatic int unsigned bcnt_w(input int unsigned burst_max);
    return $clog2(burst_max + 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester / FIFO write-port bundle around the arbiter.
//   req, req_data   - per-requester valid and data (slice i = [i*DSIZE +: DSIZE])
//   gnt, ack        - one-hot grant and per-requester beat accept
//   winc, wdata     - FIFO write enable and data
//   wfull           - FIFO full flag
//   busy, owner_id  - arbiter status
// Modports: master = arbiter side, slave = requesters / FIFO side.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int unsigned DSIZE = DSIZE_DEF,
  parameter int unsigned NREQ  = NREQ_DEF
) ();

  localparam int unsigned OwnerW = owner_w(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic                  wfull;
  logic                  busy;
  logic [OwnerW-1:0]     owner_id;

  modport master (
    input  req, req_data, wfull,
    output gnt, ack, winc, wdata, busy, owner_id
  );

  modport slave (
    output req, req_data, wfull,
    input  gnt, ack, winc, wdata, busy, owner_id
  );

endinterface

// File: rtl/rr_arb_pick.sv
// rr_arb_pick: combinational round-robin selector.
//   req_i     - request vector
//   rr_ptr_i  - first index to consider; search wraps modulo NREQ
//   sel_o     - first requesting index at or after rr_ptr_i (0 if none)
//   any_req_o - any request present
module rr_arb_pick #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned OwnerW = 2
) (
  input  logic [NREQ-1:0]   req_i,
  input  logic [OwnerW-1:0] rr_ptr_i,
  output logic [OwnerW-1:0] sel_o,
  output logic              any_req_o
);

  logic [31:0]       idx;
  logic [OwnerW-1:0] cand;
  logic              found;

  always_comb begin
    sel_o = '0;
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      // Modulo rather than bit truncation so non-power-of-2 NREQ wraps correctly.
      idx  = (32'(rr_ptr_i) + i) % NREQ;
      cand = OwnerW'(idx);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        sel_o = cand;
      end
    end
    any_req_o = |req_i;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares one FIFO write port between NREQ requesters using round-robin
// arbitration with bursts of at most BURST_MAX beats per grant, honouring wfull.
//   wclk      - clock
//   wrst      - synchronous active-high reset
//   bus       - fifo_wr_arbiter_if.master (req/req_data in, gnt/ack/winc/wdata/busy/owner_id
//               out, wfull in)
//   stall_cnt - saturating count of stalled GRANT cycles, only when FIFO_ARB_STATS_EN is defined
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned DSIZE     = DSIZE_DEF,
  parameter int unsigned NREQ      = NREQ_DEF,
  parameter int unsigned BURST_MAX = BURST_MAX_DEF
) (
  input  logic               wclk,
  input  logic               wrst,
  fifo_wr_arbiter_if.master  bus
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [STALL_W-1:0] stall_cnt
`endif
);

  localparam int unsigned OwnerW = owner_w(NREQ);
  localparam int unsigned BcntW  = bcnt_w(BURST_MAX);

  arb_state_e        state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [OwnerW-1:0] owner_q, owner_d;
  logic [OwnerW-1:0] rr_ptr_q, rr_ptr_d;
  logic [BcntW-1:0]  beat_cnt_q, beat_cnt_d;
  logic [OwnerW-1:0] sel;
  logic              any_req;
  logic              owner_req;
  logic              beat_ok;
  logic              last_beat;

  rr_arb_pick #(
    .NREQ   (NREQ),
    .OwnerW (OwnerW)
  ) u_pick (
    .req_i     (bus.req),
    .rr_ptr_i  (rr_ptr_q),
    .sel_o     (sel),
    .any_req_o (any_req)
  );

  // Write-port outputs are combinational from the registered owner, so the first beat
  // can be accepted in the same cycle the grant appears.
  always_comb begin
    owner_req    = bus.req[owner_q];
    beat_ok      = (state_q == StGrant) && owner_req && !bus.wfull;
    last_beat    = (beat_cnt_q == BcntW'(BURST_MAX - 1));
    bus.gnt      = gnt_q;
    bus.ack      = gnt_q & bus.req & {NREQ{~bus.wfull}};
    bus.winc     = |bus.ack;
    bus.wdata    = (state_q == StGrant) ? bus.req_data[owner_q*DSIZE +: DSIZE] : '0;
    bus.busy     = (state_q == StGrant);
    bus.owner_id = owner_q;
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d    = StGrant;
          gnt_d      = {{(NREQ-1){1'b0}}, 1'b1} << sel;
          owner_d    = sel;
          rr_ptr_d   = (sel == OwnerW'(NREQ - 1)) ? '0 : sel + 1'b1;
          beat_cnt_d = '0;
        end
      end
      StGrant: begin
        // Exit always lands in StIdle, giving the one-cycle bubble before the next grant.
        if (!owner_req || (beat_ok && last_beat)) begin
          state_d    = StIdle;
          gnt_d      = '0;
          beat_cnt_d = '0;
        end else if (beat_ok) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
    endcase
  end

`ifdef FIFO_ARB_STATS_EN
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == StGrant) && owner_req && bus.wfull && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q     <= StIdle;
      gnt_q       <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
`ifdef FIFO_ARB_STATS_EN
      stall_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
`ifdef FIFO_ARB_STATS_EN
      stall_cnt_q <= stall_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter. Each requester i sends beats whose data is {i, seq} with seq
// counting from 1; expected beats are queued per requester when loaded and popped when winc
// fires. Inputs are driven 1 time unit after the rising edge, outputs sampled on the falling edge.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int unsigned DSIZE      = 8;
  localparam int unsigned NREQ       = 4;
  localparam int unsigned BURST_MAX  = 4;
  localparam int unsigned FIFO_DEPTH = 16;

  logic wclk = 1'b0;
  logic wrst = 1'b1;

  fifo_wr_arbiter_if #(.DSIZE(DSIZE), .NREQ(NREQ)) bus ();

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] stall_cnt;
`endif

  fifo_wr_arbiter #(
    .DSIZE     (DSIZE),
    .NREQ      (NREQ),
    .BURST_MAX (BURST_MAX)
  ) dut (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (bus)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 wclk = ~wclk;

  int checks = 0;
  int errors = 0;

  int unsigned      rem [NREQ];
  int unsigned      sent[NREQ];
  logic [DSIZE-1:0] exp_q[NREQ][$];
  logic             wrst_v = 1'b1;
  logic             full_force = 1'b0;
  logic             use_fifo = 1'b0;
  int unsigned      fifo_cnt = 0;
  int unsigned      acc_total = 0;
  logic [NREQ-1:0]  req_v;
  logic             wfull_v;

  logic [NREQ-1:0]  obs_gnt, obs_ack;
  logic             obs_winc, obs_busy;
  logic [1:0]       obs_owner;
  logic [DSIZE-1:0] obs_wdata;

  initial begin
    bus.req      = '0;
    bus.req_data = '0;
    bus.wfull    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      rem[i]  = 0;
      sent[i] = 0;
    end
  end

  function automatic logic [DSIZE-1:0] beat_data(input int unsigned id, input int unsigned seq);
    logic [1:0] id2;
    logic [5:0] seq6;
    id2  = id[1:0];
    seq6 = seq[5:0];
    return {id2, seq6};
  endfunction

  task automatic load(input int unsigned id, input int unsigned n);
    for (int unsigned k = 1; k <= n; k++) exp_q[id].push_back(beat_data(id, sent[id] + rem[id] + k));
    rem[id] += n;
  endtask

  // One clock cycle: drive inputs, sample outputs, check cycle invariants and the scoreboard.
  task automatic tick();
    logic [NREQ*DSIZE-1:0] rd;
    logic [NREQ-1:0]       exp_ack;
    logic [DSIZE-1:0]      exp_d;
    int unsigned           id;
    @(posedge wclk);
    #1;
    rd = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_v[i] = (rem[i] != 0);
      if (rem[i] != 0) rd[i*DSIZE +: DSIZE] = beat_data(i, sent[i] + 1);
    end
    wfull_v      = use_fifo ? (fifo_cnt >= FIFO_DEPTH) : full_force;
    wrst         = wrst_v;
    bus.req      = req_v;
    bus.req_data = rd;
    bus.wfull    = wfull_v;
    @(negedge wclk);
    obs_gnt   = bus.gnt;
    obs_ack   = bus.ack;
    obs_winc  = bus.winc;
    obs_busy  = bus.busy;
    obs_owner = bus.owner_id;
    obs_wdata = bus.wdata;
    exp_ack   = obs_gnt & req_v & {NREQ{~wfull_v}};
    checks++;
    if (obs_ack !== exp_ack) begin
      errors++;
      $display("FAIL ack: got %b expected %b", obs_ack, exp_ack);
    end
    checks++;
    if (obs_winc !== (|exp_ack)) begin
      errors++;
      $display("FAIL winc: got %b expected %b", obs_winc, |exp_ack);
    end
    checks++;
    if (!$onehot0(obs_gnt)) begin
      errors++;
      $display("FAIL gnt_onehot: got %b expected one-hot or zero", obs_gnt);
    end
    checks++;
    if (obs_busy !== (obs_gnt != '0)) begin
      errors++;
      $display("FAIL busy: got %b expected %b (gnt %b)", obs_busy, obs_gnt != '0, obs_gnt);
    end
    if (!obs_busy) begin
      checks++;
      if (obs_wdata !== '0) begin
        errors++;
        $display("FAIL idle_wdata: got %h expected 00", obs_wdata);
      end
    end
    if (obs_winc === 1'b1) begin
      id = 32'(obs_wdata[DSIZE-1 -: 2]);
      checks++;
      if (exp_q[id].size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: got beat %h with no expected beat for requester %0d",
                 obs_wdata, id);
      end else begin
        exp_d = exp_q[id].pop_front();
        if (obs_wdata !== exp_d) begin
          errors++;
          $display("FAIL sb_data: got %h expected %h", obs_wdata, exp_d);
        end
        if (rem[id] != 0) rem[id]--;
        sent[id]++;
        fifo_cnt++;
        acc_total++;
      end
    end
  endtask

  task automatic do_reset();
    wrst_v = 1'b1;
    tick();
    tick();
    for (int i = 0; i < NREQ; i++) begin
      rem[i]  = 0;
      sent[i] = 0;
      exp_q[i].delete();
    end
    wrst_v     = 1'b0;
    full_force = 1'b0;
    use_fifo   = 1'b0;
    fifo_cnt   = 0;
    acc_total  = 0;
  endtask

  task automatic drain();
    for (int n = 0; n < 60; n++) begin
      if ((rem[0] | rem[1] | rem[2] | rem[3]) == 0) break;
      tick();
    end
    for (int i = 0; i < NREQ; i++) begin
      checks++;
      if (exp_q[i].size() != 0) begin
        errors++;
        $display("FAIL drain_timeout: requester %0d got %0d beats left expected 0",
                 i, exp_q[i].size());
      end
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    wrst_v = 1'b1;
    load(1, 3);
    for (int n = 0; n < 2; n++) begin
      tick();
      checks++;
      if (obs_gnt !== '0 || obs_busy !== 1'b0 || obs_owner !== 2'd0 || obs_winc !== 1'b0
          || obs_wdata !== '0) begin
        errors++;
        $display("FAIL reset_state: got gnt %b busy %b owner %0d winc %b wdata %h expected all 0",
                 obs_gnt, obs_busy, obs_owner, obs_winc, obs_wdata);
      end
    end
    wrst_v = 1'b0;
    tick();
    checks++;
    if (obs_gnt !== 4'b0000) begin
      errors++;
      $display("FAIL reset_release_idle: got gnt %b expected 0000", obs_gnt);
    end
    tick();
    checks++;
    if (obs_gnt !== 4'b0010 || obs_owner !== 2'd1) begin
      errors++;
      $display("FAIL reset_first_grant: got gnt %b owner %0d expected 0010 owner 1",
               obs_gnt, obs_owner);
    end
  endtask

  task automatic test_single_requester();
    logic [NREQ-1:0] exp_gnt [10];
    logic            exp_winc[10];
    do_reset();
    exp_gnt  = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0};
    exp_winc = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    load(0, 6);
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (obs_gnt !== exp_gnt[c] || obs_winc !== exp_winc[c]) begin
        errors++;
        $display("FAIL single_req cycle %0d: got gnt %b winc %b expected gnt %b winc %b",
                 c, obs_gnt, obs_winc, exp_gnt[c], exp_winc[c]);
      end
    end
    checks++;
    if (acc_total != 6 || exp_q[0].size() != 0) begin
      errors++;
      $display("FAIL single_req_total: got %0d beats expected 6", acc_total);
    end
  endtask

  task automatic test_round_robin();
    int unsigned own;
    do_reset();
    load(0, 8);
    load(1, 4);
    load(2, 4);
    load(3, 4);
    for (int g = 0; g < 5; g++) begin
      own = g % NREQ;
      tick();
      checks++;
      if (obs_gnt !== '0 || obs_busy !== 1'b0) begin
        errors++;
        $display("FAIL rr_bubble %0d: got gnt %b busy %b expected 0000 0", g, obs_gnt, obs_busy);
      end
      for (int b = 0; b < BURST_MAX; b++) begin
        tick();
        checks++;
        if (obs_gnt !== (4'b0001 << own) || obs_owner !== 2'(own) || obs_winc !== 1'b1) begin
          errors++;
          $display("FAIL rr_grant %0d beat %0d: got gnt %b owner %0d winc %b expected owner %0d",
                   g, b, obs_gnt, obs_owner, obs_winc, own);
        end
      end
    end
    tick();
    checks++;
    if (obs_gnt !== '0 || acc_total != 20) begin
      errors++;
      $display("FAIL rr_end: got gnt %b beats %0d expected 0000 and 20", obs_gnt, acc_total);
    end
  endtask

  task automatic test_wfull_stall();
    do_reset();
    load(0, 4);
    tick();
    for (int b = 0; b < 2; b++) begin
      tick();
      checks++;
      if (obs_winc !== 1'b1) begin
        errors++;
        $display("FAIL stall_pre beat %0d: got winc %b expected 1", b, obs_winc);
      end
    end
    full_force = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (obs_winc !== 1'b0 || obs_gnt !== 4'b0001) begin
        errors++;
        $display("FAIL stall_hold %0d: got winc %b gnt %b expected 0 0001", c, obs_winc, obs_gnt);
      end
    end
    full_force = 1'b0;
    for (int b = 0; b < 2; b++) begin
      tick();
      checks++;
      if (obs_winc !== 1'b1 || obs_gnt !== 4'b0001) begin
        errors++;
        $display("FAIL stall_resume %0d: got winc %b gnt %b expected 1 0001",
                 b, obs_winc, obs_gnt);
      end
    end
    tick();
    checks++;
    if (obs_gnt !== '0 || acc_total != 4) begin
      errors++;
      $display("FAIL stall_total: got gnt %b beats %0d expected 0000 and 4", obs_gnt, acc_total);
    end
  endtask

  task automatic test_owner_drop();
    logic [NREQ-1:0] exp_gnt [5];
    logic            exp_winc[5];
    do_reset();
    exp_gnt  = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h4};
    exp_winc = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    load(0, 1);
    load(2, 3);
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (obs_gnt !== exp_gnt[c] || obs_winc !== exp_winc[c]) begin
        errors++;
        $display("FAIL owner_drop cycle %0d: got gnt %b winc %b expected gnt %b winc %b",
                 c, obs_gnt, obs_winc, exp_gnt[c], exp_winc[c]);
      end
    end
    drain();
  endtask

  task automatic test_mid_burst_reset();
    do_reset();
    load(2, 4);
    tick();
    tick();
    tick();
    checks++;
    if (obs_gnt !== 4'b0100 || obs_owner !== 2'd2) begin
      errors++;
      $display("FAIL midrst_pre: got gnt %b owner %0d expected 0100 owner 2", obs_gnt, obs_owner);
    end
    wrst_v = 1'b1;
    tick();
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = 0;
      exp_q[i].delete();
    end
    load(1, 2);
    load(3, 2);
    wrst_v = 1'b0;
    tick();
    checks++;
    if (obs_gnt !== '0 || obs_winc !== 1'b0 || obs_owner !== 2'd0 || obs_busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_after: got gnt %b winc %b owner %0d busy %b expected 0000 0 0 0",
               obs_gnt, obs_winc, obs_owner, obs_busy);
    end
    tick();
    checks++;
    if (obs_gnt !== 4'b0010 || obs_owner !== 2'd1) begin
      errors++;
      $display("FAIL midrst_regrant: got gnt %b owner %0d expected 0010 owner 1",
               obs_gnt, obs_owner);
    end
    drain();
  endtask

  task automatic test_fifo_full();
    bit found;
    do_reset();
    use_fifo = 1'b1;
    load(0, 20);
    for (int n = 0; n < 60 && acc_total < FIFO_DEPTH; n++) tick();
    found = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick();
      if (obs_busy && wfull_v) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found || acc_total != FIFO_DEPTH) begin
      errors++;
      $display("FAIL fifo_fill: got %0d beats stalled %b expected 16 and 1", acc_total, found);
    end
`ifdef FIFO_ARB_STATS_EN
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL stall_cnt_start: got %0d expected 0", stall_cnt);
    end
`endif
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if (obs_winc !== 1'b0 || obs_gnt !== 4'b0001) begin
        errors++;
        $display("FAIL fifo_stall %0d: got winc %b gnt %b expected 0 0001", k, obs_winc, obs_gnt);
      end
`ifdef FIFO_ARB_STATS_EN
      checks++;
      if (stall_cnt !== 16'(k)) begin
        errors++;
        $display("FAIL stall_cnt_inc: got %0d expected %0d", stall_cnt, k);
      end
`endif
    end
    checks++;
    if (acc_total != FIFO_DEPTH) begin
      errors++;
      $display("FAIL fifo_total: got %0d beats expected 16", acc_total);
    end
    wrst_v = 1'b1;
    tick();
    wrst_v = 1'b0;
    tick();
`ifdef FIFO_ARB_STATS_EN
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL stall_cnt_clear: got %0d expected 0", stall_cnt);
    end
`endif
    do_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_requester();
    test_round_robin();
    test_wfull_stall();
    test_owner_drop();
    test_mid_burst_reset();
    test_fifo_full();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Write-side arbiter that shares the single FIFO write port (winc/wdata/wfull) between NREQ requesters in the wclk domain. It uses round-robin arbitration with bounded bursts of up to BURST_MAX beats per grant. It sits in front of the FIFO write port and honours wfull back-pressure. No data is lost or duplicated.

Parameters:
DSIZE, 8, data width; must match the FIFO DSIZE.
NREQ, 4, number of requesters; must be >= 2.
BURST_MAX, 4, maximum beats per grant; must be >= 1.

Ports:
wclk  in  1  write-domain clock; the block's only clock.
wrst  in  1  reset, synchronous to wclk, active-high.
req  in  NREQ  per-requester valid; data is presented with it.
req_data  in  NREQ*DSIZE  per-requester data; slice i is bits [i*DSIZE +: DSIZE].
gnt  out  NREQ  one-hot grant, registered; all zeros when idle.
ack  out  NREQ  beat accepted this cycle: gnt[i] & req[i] & ~wfull.
winc  out  1  FIFO write enable; equals OR of ack.
wdata  out  DSIZE  req_data slice of the owner; 0 when idle.
wfull  in  1  FIFO full flag.
busy  out  1  high in the GRANT state.
owner_id  out  clog2(NREQ)  index of the current owner; holds its last value when idle.

Behaviour:
- States: IDLE, GRANT. All state is registered on the wclk rising edge.
- Reset (wrst=1 at a clock edge) takes effect that edge, including mid-burst:
  - state=IDLE, gnt=0, busy=0, owner_id=0, beat_cnt=0, rr_ptr=0.
  - winc=0, ack=0 and wdata=0 follow combinationally from the reset state.
- IDLE:
  - If any req is high, select the first requester at or after rr_ptr, wrapping modulo NREQ.
  - Next cycle: state=GRANT, gnt=onehot(sel), owner_id=sel, rr_ptr=(sel+1) mod NREQ, beat_cnt=0.
- GRANT:
  - winc and ack are combinational from the registered owner, req and wfull.
  - A beat is accepted when req[owner]=1 and wfull=0; beat_cnt then increments.
- Latency: req rises in cycle N, gnt is high in N+1, and the first beat can be accepted in N+1.
- GRANT exit, to IDLE on the next edge:
  - (a) a beat is accepted with beat_cnt == BURST_MAX-1; or
  - (b) req[owner]=0.
  - After exit there is always exactly one IDLE bubble cycle before the next grant.
- wfull=1 during GRANT:
  - winc=0, ack=0; beat_cnt and the grant are held.
  - No timeout; the burst resumes when wfull falls.
- An owner that keeps req high after a BURST_MAX exit competes again via rr_ptr. It is not re-granted while others are waiting.
- Width rules:
  - beat_cnt width is clog2(BURST_MAX+1).
  - The rr_ptr increment wraps modulo NREQ, including non-power-of-2 NREQ.
- Invariants:
  - gnt is always one-hot or zero.
  - winc never fires while wfull=1.
  - winc is always 0 in IDLE.

Optional Feature:
FIFO_ARB_STATS_EN
- Defined: adds an output stall_cnt [15:0]. It increments each GRANT cycle with req[owner]=1 and wfull=1, saturates at 16'hFFFF, and is cleared by wrst.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package fifo_arb_pkg holds:
  - the state enum (IDLE, GRANT);
  - width constants OWNER_W=clog2(NREQ) and BCNT_W=clog2(BURST_MAX+1);
  - the stall counter width, 16.
- One sub-module, rr_arb_pick: combinational round-robin selector. Inputs req and rr_ptr; outputs sel index and any_req.

Test Plan:
1. Reset, then req=4'b0001 held for 6 beats, wfull=0 -> gnt=4'b0001 from cycle 1; ack in 4 consecutive cycles; 1 IDLE cycle; regrant to 0; 2 more acks; FIFO receives data 1..6 in order.
2. req=4'b1111 held continuously -> grant order 0,1,2,3,0; 4 beats each; exactly one idle cycle between grants; owner_id tracks the owner.
3. wfull forced to 1 after the 2nd beat for 5 cycles -> winc=0 and gnt held throughout; burst finishes with beats 3-4 after release; total 4 acks.
4. Owner drops req after 1 beat, with req[2] pending -> IDLE next cycle, then gnt=4'b0100.
5. wrst pulsed mid-burst -> next cycle gnt=0, winc=0, owner_id=0; after release with req=4'b1010, gnt=4'b0010.
6. With FIFO_ARB_STATS_EN and a real 16-deep FIFO with no reads: requester 0 has 20 beats -> 16 accepted, then wfull stalls; stall_cnt increments each stalled cycle; wrst clears it to 0.
